shift_add_mul: RTL

Parametrised sequential multiplier: shift-and-add datapath plus FSM controller. Successor to the repeated-addition multiplier. Takes W+2 cycles worst case instead of B+3. Adds signed mode, early termination, a busy/done handshake and async reset. Sits beside the other datapath/control-path blocks and is driven by a master FSM through a start/done handshake.

---
 rtl/shift_add_mul_pkg.sv | 19 +
 rtl/shift_add_mul_if.sv | 22 ++
 rtl/shift_add_mul_datapath.sv | 67 ++++++
 rtl/shift_add_mul.sv | 86 ++++++++
 4 files changed

// File: rtl/shift_add_mul_pkg.sv
// Shared types for the shift-and-add multiplier: controller states and a bit-length helper.
package mul_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    // Number of significant bits in v; bitlen(0) = 0.
    function automatic int unsigned bitlen(input logic [63:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < 64; i++) begin
            if (v[i]) n = i + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/shift_add_mul_if.sv
// Start/done operand and result bundle between a controlling FSM and the multiplier.
interface shift_add_mul_if #(
    parameter int WIDTH = 16
);
    logic                 start;
    logic                 signed_mode;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, signed_mode, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/shift_add_mul_datapath.sv
// Shift-and-add datapath: operand magnitudes, accumulator, shifter and sign fix-up.
// One shift step per cycle while step_i; load_i wins over step_i; no backpressure.
module mul_sa_datapath
    import mul_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic                 step_i,
    input  logic                 signed_mode_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 mult_zero_o,
    output logic [2*WIDTH-1:0]   result_o
);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mult_q, mult_d;
    logic               neg_q, neg_d;
    logic               signed_eff;
    logic [WIDTH-1:0]   a_mag, b_mag;

    assign signed_eff = SIGNED_EN && signed_mode_i;

    // Negating the most negative value yields 2^(WIDTH-1), correct as an unsigned magnitude.
    assign a_mag = (signed_eff && a_i[WIDTH-1]) ? -a_i : a_i;
    assign b_mag = (signed_eff && b_i[WIDTH-1]) ? -b_i : b_i;

    always_comb begin
        acc_d   = acc_q;
        mcand_d = mcand_q;
        mult_d  = mult_q;
        neg_d   = neg_q;
        if (load_i) begin
            acc_d   = '0;
            mcand_d = {{WIDTH{1'b0}}, a_mag};
            mult_d  = b_mag;
            neg_d   = signed_eff && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
        end else if (step_i) begin
            if (mult_q[0]) acc_d = acc_q + mcand_q;
            mcand_d = mcand_q << 1;
            mult_d  = mult_q >> 1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            mcand_q <= '0;
            mult_q  <= '0;
            neg_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            mult_q  <= mult_d;
            neg_q   <= neg_d;
        end
    end

    assign mult_zero_o = (mult_q == '0);
    assign result_o    = neg_q ? -acc_q : acc_q;

endmodule

// File: rtl/shift_add_mul.sv
// Sequential shift-and-add multiplier controller; done arrives 2 + bitlen(|b|) cycles after accept.
// No backpressure: start is only sampled while idle, and is accepted in the done cycle.
module shift_add_mul
    import mul_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    shift_add_mul_if.slave bus
);

    state_t             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic               load;
    logic               step;
    logic               mult_zero;
    logic [2*WIDTH-1:0] result;

    mul_sa_datapath #(
        .WIDTH     (WIDTH),
        .SIGNED_EN (SIGNED_EN)
    ) u_datapath (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_i        (load),
        .step_i        (step),
        .signed_mode_i (bus.signed_mode),
        .a_i           (bus.a),
        .b_i           (bus.b),
        .mult_zero_o   (mult_zero),
        .result_o      (result)
    );

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        product_d = product_q;
        load      = 1'b0;
        step      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    busy_d  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                // Multiplier exhausted: publish the result on the same edge that returns to IDLE.
                if (mult_zero) begin
                    product_d = result;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end else begin
                    step = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;

endmodule
